// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: owns HI/LO, sequences MULT/DIV onto external units, handles MTHI/MTLO and flush.
// Define HILO_FWD_EN to forward HI/LO writes combinationally and release hilo_stall in the completion cycle.
module hilo_muldiv_ctrl #(
   parameter int MUL_LAT = 3,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        flush,
   input  logic        id_hilo_use,
   input  logic        ex_mul,
   input  logic        ex_div,
   input  logic        ex_signed,
   input  logic        ex_mthi,
   input  logic        ex_mtlo,
   input  logic [31:0] ex_src_a,
   input  logic [31:0] ex_src_b,
   output logic        mul_start,
   output logic        mul_signed,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   input  logic [63:0] mul_prod,
   output logic        div_in_valid,
   input  logic        div_in_ready,
   output logic        div_signed,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   input  logic        div_out_valid,
   input  logic [31:0] div_quot,
   input  logic [31:0] div_rem,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        hilo_stall
);
   typedef enum logic [2:0] {IDLE, MUL_WAIT, DIV_REQ, DIV_WAIT, DIV_DRAIN} state_t;
   state_t           state_q, state_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d;
   logic [31:0]      mul_a_q, mul_a_d, mul_b_q, mul_b_d, div_a_q, div_a_d, div_b_q, div_b_d;
   logic             mul_start_q, mul_start_d, mul_signed_q, mul_signed_d, div_signed_q, div_signed_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         hi_q         <= '0;
         lo_q         <= '0;
         mul_a_q      <= '0;
         mul_b_q      <= '0;
         div_a_q      <= '0;
         div_b_q      <= '0;
         mul_start_q  <= 1'b0;
         mul_signed_q <= 1'b0;
         div_signed_q <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         mul_a_q      <= mul_a_d;
         mul_b_q      <= mul_b_d;
         div_a_q      <= div_a_d;
         div_b_q      <= div_b_d;
         mul_start_q  <= mul_start_d;
         mul_signed_q <= mul_signed_d;
         div_signed_q <= div_signed_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      mul_a_d      = mul_a_q;
      mul_b_d      = mul_b_q;
      div_a_d      = div_a_q;
      div_b_d      = div_b_q;
      mul_start_d  = 1'b0;
      mul_signed_d = mul_signed_q;
      div_signed_d = div_signed_q;
      cnt_d        = cnt_q;
      case (state_q)
         IDLE: if (!flush) begin
            if (ex_div) begin
               div_a_d      = ex_src_a;
               div_b_d      = ex_src_b;
               div_signed_d = ex_signed;
               state_d      = DIV_REQ;
            end else if (ex_mul) begin
               mul_a_d      = ex_src_a;
               mul_b_d      = ex_src_b;
               mul_signed_d = ex_signed;
               mul_start_d  = 1'b1;
               cnt_d        = CNT_W'(MUL_LAT);
               state_d      = MUL_WAIT;
            end else begin
               hi_d = ex_mthi ? ex_src_a : hi_q;
               lo_d = ex_mtlo ? ex_src_a : lo_q;
            end
         end
         // The counter holds during the launch cycle so mul_prod is sampled MUL_LAT cycles after mul_start.
         MUL_WAIT: if (flush) begin
            state_d = IDLE;
         end else if (!mul_start_q) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               {hi_d, lo_d} = mul_prod;
               state_d      = IDLE;
            end
         end
         DIV_REQ: if (div_in_ready) state_d = flush ? DIV_DRAIN : DIV_WAIT;
            else if (flush) state_d = IDLE;
         DIV_WAIT: if (div_out_valid) begin
            hi_d    = flush ? hi_q : div_rem;
            lo_d    = flush ? lo_q : div_quot;
            state_d = IDLE;
         end else if (flush) begin
            state_d = DIV_DRAIN;
         end
         DIV_DRAIN: if (div_out_valid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy         = state_q != IDLE;
   assign mul_start    = mul_start_q;
   assign mul_signed   = mul_signed_q;
   assign mul_a        = mul_a_q;
   assign mul_b        = mul_b_q;
   assign div_in_valid = state_q == DIV_REQ;
   assign div_signed   = div_signed_q;
   assign div_a        = div_a_q;
   assign div_b        = div_b_q;

`ifdef HILO_FWD_EN
   logic done;
   assign done = !flush && ((state_q == MUL_WAIT && !mul_start_q && cnt_q == CNT_W'(1)) ||
                            (state_q == DIV_WAIT && div_out_valid));
   assign hi         = hi_d;
   assign lo         = lo_d;
   assign hilo_stall = id_hilo_use & ((busy & ~done) | ex_mul | ex_div);
`else
   assign hi         = hi_q;
   assign lo         = lo_q;
   assign hilo_stall = id_hilo_use & (busy | ex_mul | ex_div);
`endif
endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb_hilo_muldiv_ctrl: scoreboard bench for hilo_muldiv_ctrl with a 3-stage multiplier model and a scripted divider.
module tb_hilo_muldiv_ctrl;
   logic        clk = 1'b0, resetn = 1'b0, flush = 1'b0, id_hilo_use = 1'b0;
   logic        ex_mul = 1'b0, ex_div = 1'b0, ex_signed = 1'b0, ex_mthi = 1'b0, ex_mtlo = 1'b0;
   logic [31:0] ex_src_a = '0, ex_src_b = '0;
   logic        mul_start, mul_signed;
   logic [31:0] mul_a, mul_b;
   logic [63:0] mul_prod, prod, p0, p1, p2;
   logic [2:0]  v_pipe = '0;
   logic        div_in_valid, div_in_ready = 1'b0, div_signed, div_out_valid = 1'b0;
   logic [31:0] div_a, div_b, div_quot = '0, div_rem = '0, hi, lo;
   logic        busy, hilo_stall;
   int          errors = 0, checks = 0;
   logic [63:0] sb[$];
   logic [63:0] exp_hl;
`ifdef HILO_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   hilo_muldiv_ctrl dut (
      .clk(clk), .resetn(resetn), .flush(flush), .id_hilo_use(id_hilo_use),
      .ex_mul(ex_mul), .ex_div(ex_div), .ex_signed(ex_signed), .ex_mthi(ex_mthi), .ex_mtlo(ex_mtlo),
      .ex_src_a(ex_src_a), .ex_src_b(ex_src_b),
      .mul_start(mul_start), .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b), .mul_prod(mul_prod),
      .div_in_valid(div_in_valid), .div_in_ready(div_in_ready), .div_signed(div_signed),
      .div_a(div_a), .div_b(div_b), .div_out_valid(div_out_valid), .div_quot(div_quot), .div_rem(div_rem),
      .hi(hi), .lo(lo), .busy(busy), .hilo_stall(hilo_stall)
   );

   always #5 clk = ~clk;

   // Multiplier model: product valid only in the cycle exactly 3 cycles after mul_start.
   assign prod = {{32{mul_signed & mul_a[31]}}, mul_a} * {{32{mul_signed & mul_b[31]}}, mul_b};
   always @(posedge clk) begin
      v_pipe <= {v_pipe[1:0], mul_start};
      p0     <= prod;
      p1     <= p0;
      p2     <= p1;
   end
   assign mul_prod = v_pipe[2] ? p2 : 64'hDEAD_BEEF_DEAD_BEEF;

   always @(posedge clk) begin
      if (resetn && busy && (ex_mul || ex_div)) begin
         errors++;
         $display("FAIL protocol ex_mul/ex_div issued while busy");
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      tick;
      checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if ({mul_start, div_in_valid} !== 2'b00) begin errors++; $display("FAIL reset_strobes got=%b exp=00", {mul_start, div_in_valid}); end
      checks++; if ({mul_a, mul_b, div_a, div_b} !== 128'h0) begin errors++; $display("FAIL reset_operands got=%h exp=0", {mul_a, mul_b, div_a, div_b}); end
      tick;
      resetn = 1'b1;
      tick;
      checks++; if ({busy, hilo_stall} !== 2'b00) begin errors++; $display("FAIL post_reset_idle got=%b exp=00", {busy, hilo_stall}); end
   endtask

   task automatic test_mult;
      int bc;
      id_hilo_use = 1'b1; ex_mul = 1'b1; ex_signed = 1'b1; ex_src_a = 32'hFFFF_FFFE; ex_src_b = 32'd3;
      sb.push_back(64'hFFFF_FFFF_FFFF_FFFA);
      #1;
      checks++; if (hilo_stall !== 1'b1) begin errors++; $display("FAIL mul_launch_stall got=%b exp=1", hilo_stall); end
      tick;
      ex_mul = 1'b0; ex_signed = 1'b0; ex_src_a = '0; ex_src_b = '0;
      checks++; if ({mul_start, mul_signed, mul_a, mul_b} !== {1'b1, 1'b1, 32'hFFFF_FFFE, 32'd3})
         begin errors++; $display("FAIL mul_launch got=%b %b %h %h exp=1 1 fffffffe 00000003", mul_start, mul_signed, mul_a, mul_b); end
      bc = 0;
      for (int i = 1; i <= 20 && busy; i++) begin
         bc++;
         if (i == 4) begin
            checks++; if (hilo_stall !== !FWD) begin errors++; $display("FAIL mul_done_stall got=%b exp=%b", hilo_stall, !FWD); end
         end
         tick;
         if (i == 1) begin
            checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL mul_start_pulse got=%b exp=0", mul_start); end
         end
      end
      checks++; if (bc != 4) begin errors++; $display("FAIL mul_busy_cycles got=%0d exp=4", bc); end
      exp_hl = sb.pop_front();
      checks++; if ({hi, lo} !== exp_hl) begin errors++; $display("FAIL mul_result got=%h exp=%h", {hi, lo}, exp_hl); end
      id_hilo_use = 1'b0;
   endtask

   task automatic test_divu;
      id_hilo_use = 1'b1; ex_div = 1'b1; ex_signed = 1'b0; ex_src_a = 32'd100; ex_src_b = 32'd7;
      sb.push_back({32'd2, 32'd14});
      tick;
      ex_div = 1'b0; ex_src_a = '0; ex_src_b = '0;
      for (int i = 1; i <= 3; i++) begin
         div_in_ready = (i == 3);
         #1;
         checks++; if ({div_in_valid, div_signed, div_a, div_b} !== {1'b1, 1'b0, 32'd100, 32'd7})
            begin errors++; $display("FAIL div_req_c%0d got=%b %b %0d %0d exp=1 0 100 7", i, div_in_valid, div_signed, div_a, div_b); end
         checks++; if (hilo_stall !== 1'b1) begin errors++; $display("FAIL div_stall_c%0d got=%b exp=1", i, hilo_stall); end
         tick;
      end
      div_in_ready = 1'b0;
      checks++; if ({div_in_valid, busy} !== 2'b01) begin errors++; $display("FAIL div_wait got=%b exp=01", {div_in_valid, busy}); end
      tick;
      div_out_valid = 1'b1; div_quot = 32'd14; div_rem = 32'd2;
      #1;
      checks++; if (hilo_stall !== !FWD) begin errors++; $display("FAIL div_done_stall got=%b exp=%b", hilo_stall, !FWD); end
      tick;
      div_out_valid = 1'b0; div_quot = '0; div_rem = '0;
      #1;
      checks++; if ({busy, hilo_stall} !== 2'b00) begin errors++; $display("FAIL div_release got=%b exp=00", {busy, hilo_stall}); end
      exp_hl = sb.pop_front();
      checks++; if ({hi, lo} !== exp_hl) begin errors++; $display("FAIL div_result got=%h exp=%h", {hi, lo}, exp_hl); end
      id_hilo_use = 1'b0;
   endtask

   task automatic test_mthi_mtlo;
      sb.push_back({32'h1234_5678, 32'h9ABC_DEF0});
      ex_mthi = 1'b1; ex_src_a = 32'h1234_5678;
      tick;
      checks++; if ({busy, hi} !== {1'b0, 32'h1234_5678}) begin errors++; $display("FAIL mthi got=%b %h exp=0 12345678", busy, hi); end
      ex_mthi = 1'b0; ex_mtlo = 1'b1; ex_src_a = 32'h9ABC_DEF0;
      tick;
      ex_mtlo = 1'b0;
      exp_hl = sb.pop_front();
      checks++; if ({busy, hi, lo} !== {1'b0, exp_hl}) begin errors++; $display("FAIL mtlo got=%b %h exp=0 %h", busy, {hi, lo}, exp_hl); end
      flush = 1'b1; ex_mthi = 1'b1; ex_src_a = 32'hFFFF_FFFF;
      tick;
      flush = 1'b0; ex_mthi = 1'b0; ex_src_a = '0;
      checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL flush_mthi got=%h exp=12345678", hi); end
   endtask

   task automatic test_div_flush;
      sb.push_back({32'h1234_5678, 32'h9ABC_DEF0});
      ex_div = 1'b1; ex_src_a = 32'd50; ex_src_b = 32'd5;
      tick;
      ex_div = 1'b0; div_in_ready = 1'b1;
      tick;
      div_in_ready = 1'b0; flush = 1'b1;
      tick;
      flush = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy got=%b exp=1", busy); end
      tick;
      div_out_valid = 1'b1; div_quot = 32'd10; div_rem = 32'd0;
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drain_busy_last got=%b exp=1", busy); end
      tick;
      div_out_valid = 1'b0;
      exp_hl = sb.pop_front();
      checks++; if ({busy, hi, lo} !== {1'b0, exp_hl}) begin errors++; $display("FAIL drain_done got=%b %h exp=0 %h", busy, {hi, lo}, exp_hl); end
      ex_div = 1'b1;
      tick;
      ex_div = 1'b0; flush = 1'b1;
      tick;
      flush = 1'b0;
      checks++; if ({busy, div_in_valid} !== 2'b00) begin errors++; $display("FAIL req_flush got=%b exp=00", {busy, div_in_valid}); end
      ex_div = 1'b1;
      tick;
      ex_div = 1'b0; div_in_ready = 1'b1;
      tick;
      div_in_ready = 1'b0; div_out_valid = 1'b1; flush = 1'b1;
      tick;
      div_out_valid = 1'b0; flush = 1'b0;
      checks++; if ({busy, hi, lo} !== {1'b0, exp_hl}) begin errors++; $display("FAIL wait_flush_result got=%b %h exp=0 %h", busy, {hi, lo}, exp_hl); end
   endtask

   task automatic test_mul_flush;
      sb.push_back({32'h1234_5678, 32'h9ABC_DEF0});
      ex_mul = 1'b1; ex_signed = 1'b0; ex_src_a = 32'd7; ex_src_b = 32'd9;
      tick;
      ex_mul = 1'b0;
      tick;
      tick;
      flush = 1'b1;
      tick;
      flush = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_flush_idle got=%b exp=0", busy); end
      tick;
      tick;
      exp_hl = sb.pop_front();
      checks++; if ({busy, hi, lo} !== {1'b0, exp_hl}) begin errors++; $display("FAIL mul_flush_hilo got=%b %h exp=0 %h", busy, {hi, lo}, exp_hl); end
   endtask

   task automatic test_reset_mid_div;
      ex_div = 1'b1; ex_src_a = 32'd9; ex_src_b = 32'd3;
      tick;
      ex_div = 1'b0; div_in_ready = 1'b1;
      tick;
      div_in_ready = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got=%b exp=1", busy); end
      #1 resetn = 1'b0;
      #1;
      checks++; if ({busy, div_in_valid} !== 2'b00) begin errors++; $display("FAIL rst_async_ctrl got=%b exp=00", {busy, div_in_valid}); end
      checks++; if ({hi, lo, div_a} !== 96'h0) begin errors++; $display("FAIL rst_async_regs got=%h exp=0", {hi, lo, div_a}); end
      resetn = 1'b1;
      tick;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_release got=%b exp=0", busy); end
   endtask

   initial begin
      test_reset;
      test_mult;
      test_divu;
      test_mthi_mtlo;
      test_div_flush;
      test_mul_flush;
      test_reset_mid_div;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Owns the architectural HI/LO registers and schedules multi-cycle MULT/MULTU/DIV/DIVU onto an external fixed-latency multiplier and an external valid/ready iterative divider.
- Sits beside the EX stage. Replaces decode's ad-hoc div_valid tracking with one busy/stall source for every HI/LO-touching instruction in ID.
- Handles MTHI/MTLO writes and exception flush.

Parameters:
- MUL_LAT, 3, cycles from mul_start to a valid mul_prod (legal range 1..15).
- CNT_W, 4, width of the multiplier latency counter.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  exception/ERET sweep; aborts any in-flight operation
- id_hilo_use  in  1  ID holds MFHI/MFLO/MTHI/MTLO/MULT*/DIV*
- ex_mul  in  1  MULT/MULTU in EX, single-cycle pulse
- ex_div  in  1  DIV/DIVU in EX, single-cycle pulse
- ex_signed  in  1  signed variant
- ex_mthi  in  1  MTHI in EX
- ex_mtlo  in  1  MTLO in EX
- ex_src_a  in  32  rs operand
- ex_src_b  in  32  rt operand
- mul_start  out  1  multiplier launch pulse
- mul_signed  out  1  signed multiply
- mul_a, mul_b  out  32 each  registered operands
- mul_prod  in  64  product, valid MUL_LAT cycles after mul_start
- div_in_valid  out  1  divider request
- div_in_ready  in  1  divider accepts request
- div_signed  out  1  signed divide
- div_a, div_b  out  32 each  dividend / divisor
- div_out_valid  in  1  divider result pulse
- div_quot, div_rem  in  32 each  quotient / remainder
- hi, lo  out  32 each  HI/LO values
- busy  out  1  operation in flight
- hilo_stall  out  1  stall request to ID

Behaviour:
- Reset (asynchronous): state IDLE; hi=lo=0; all strobes 0; mul_a/mul_b/div_a/div_b=0; counter 0.
- States:
  - IDLE
  - MUL_WAIT
  - DIV_REQ
  - DIV_WAIT
  - DIV_DRAIN
- IDLE, in priority order:
  - flush: ignore all ex_* inputs.
  - ex_div: latch operands and signedness into div_a/div_b/div_signed; go to DIV_REQ.
  - ex_mul: latch mul_a/mul_b/mul_signed; pulse mul_start next cycle; load counter with MUL_LAT; go to MUL_WAIT.
  - ex_mthi: hi<=ex_src_a next edge. ex_mtlo: lo<=ex_src_a next edge.
  - ex_mthi and ex_mtlo can never be asserted together; if both are asserted, both registers are written.
- MUL_WAIT:
  - Counter decrements each cycle.
  - At counter==1: {hi,lo}<=mul_prod; return to IDLE. Total latency is MUL_LAT+1 cycles from ex_mul.
- DIV_REQ:
  - div_in_valid=1 and held with stable operands until div_in_ready.
  - On the handshake, go to DIV_WAIT.
- DIV_WAIT: on div_out_valid, lo<=div_quot, hi<=div_rem; go to IDLE.
- Divide by zero: no trap; the divider's result is written unchanged.
- Flush:
  - In MUL_WAIT: abort, discard the result, HI/LO unchanged, go to IDLE. A late mul_prod is ignored.
  - In DIV_REQ before the handshake: drop div_in_valid, go to IDLE.
  - In DIV_REQ with the handshake in the same cycle: go to DIV_DRAIN.
  - In DIV_WAIT: go to DIV_DRAIN.
  - DIV_DRAIN: wait for div_out_valid and discard it; go to IDLE. busy stays 1 throughout.
  - flush in the same cycle as div_out_valid in DIV_WAIT: result discarded.
- busy = (state != IDLE).
- hilo_stall = id_hilo_use & (busy | ex_mul | ex_div). A new HI/LO instruction never enters EX while an operation is pending or launching.
- ex_mul/ex_div while busy is a protocol violation. It is ignored, and the bench asserts it never happens.
- Only MUL_WAIT/DIV_WAIT completions and MTHI/MTLO write HI/LO.

Optional Feature:
- Macro: HILO_FWD_EN.
- Defined: hi/lo outputs combinationally present the value being written in the completion/MT cycle. hilo_stall drops in the completion cycle, so an MFHI waiting in ID issues one cycle earlier.
- Undefined: hi/lo are pure register outputs. hilo_stall stays high through the completion cycle and releases one cycle after HI/LO update.

Test Plan:
- MULT, src_a=0xFFFF_FFFE, src_b=3, signed, MUL_LAT=3 -> mul_start one cycle later; hi=0xFFFF_FFFF, lo=0xFFFF_FFFA four cycles after ex_mul; busy high exactly 4 cycles.
- DIVU, 100/7, div_in_ready delayed 2 cycles, result 5 cycles later -> div_in_valid held 3 cycles with stable operands; lo=14, hi=2; MFLO in ID stalled until completion (timing per macro).
- MTHI 0x1234_5678 in IDLE, then MTLO 0x9ABC_DEF0 -> hi/lo updated on the next edges; busy never asserted.
- DIV accepted, flush in DIV_WAIT, div_out_valid two cycles later -> DIV_DRAIN entered; HI/LO unchanged; busy falls the cycle after div_out_valid.
- MULT issued, flush at counter==2 -> IDLE next cycle; HI/LO unchanged.
- resetn asserted mid-DIV_WAIT -> immediate IDLE, hi=lo=0, div_in_valid=0.
